// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_ctrl_pkg
//  Description : Shared constants, types and helpers for the issue controller
//                and its outstanding-operation slots.
//  Revision    : 1.0 - initial release
// ============================================================================
package issue_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_SLOTS  = 2;
   localparam int SLOT_LD    = 0;
   localparam int SLOT_DIV   = 1;

   // Slot state encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Register x0 never carries a dependency, so a zero address never matches.
   function automatic logic addr_match(input reg_addr_t a, input reg_addr_t b);
      return (a != '0) && (a == b);
   endfunction

endpackage
`default_nettype wire

// File: rtl/issue_slot.sv
`default_nettype none
// ============================================================================
//  Module      : issue_slot
//  Description : One outstanding long-latency operation slot. Holds a busy
//                state and the destination register captured at issue, and
//                reports whether the decoded instruction depends on it.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_slot
   import issue_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      capture,
   input  logic      done,
   input  reg_addr_t rs1_addr,
   input  reg_addr_t rs2_addr,
   input  reg_addr_t rd_addr,
   input  logic      rd_we,
   output logic      busy,
   output logic      data_hit,
   output logic      spurious_done
);

   logic [0:0] state;
   reg_addr_t  slot_rd;
   logic       slot_rd_valid;

   // Slot state: occupied on issue, released on the edge where done is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
         if (capture) state <= ST_BUSY;
      end else begin
         if (done) state <= ST_IDLE;
      end
   end

   // Destination capture; a write to x0 or a non-writing op holds the slot
   // structurally but never creates a data dependency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_rd       <= '0;
         slot_rd_valid <= 1'b0;
      end else if (capture && (state == ST_IDLE)) begin
         slot_rd       <= rd_addr;
         slot_rd_valid <= rd_we && (rd_addr != '0);
      end
   end

   assign busy          = (state == ST_BUSY);
   assign spurious_done = done && (state == ST_IDLE);

   // RAW on either source, or WAW on the destination, against registered state only.
   always_comb begin
      data_hit = busy && slot_rd_valid &&
                 (addr_match(rs1_addr, slot_rd) ||
                  addr_match(rs2_addr, slot_rd) ||
                  (rd_we && addr_match(rd_addr, slot_rd)));
   end

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : issue_ctrl
//  Description : In-order issue controller with one load and one divide
//                outstanding slot. Detects data and structural hazards,
//                produces issue/stall, counts stall cycles and flags
//                protocol errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec_valid_i,
   input  reg_addr_t        rs1_raddr_i,
   input  reg_addr_t        rs2_raddr_i,
   input  reg_addr_t        rd_waddr_i,
   input  logic             rd_we_i,
   input  logic             dec_load_i,
   input  logic             dec_div_i,
   input  logic             flush_i,
   input  logic             ld_done_i,
   input  logic             div_done_i,
   input  logic             clr_cnt_i,
   output logic             issue_o,
   output logic             stall_o,
   output logic             ld_busy_o,
   output logic             div_busy_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_SLOTS-1:0] slot_capture;
   logic [NUM_SLOTS-1:0] slot_done;
   logic [NUM_SLOTS-1:0] slot_busy;
   logic [NUM_SLOTS-1:0] slot_hit;
   logic [NUM_SLOTS-1:0] slot_spurious;
   logic                 op_conflict;
   logic                 struct_hazard;
   logic                 hazard;
   logic [CNT_W-1:0]     stall_cnt;
   logic                 err;

   assign slot_done[SLOT_LD]  = ld_done_i;
   assign slot_done[SLOT_DIV] = div_done_i;

   // Hazard resolution and issue decision; an instruction flagged as both
   // load and divide is malformed and is never allowed to issue.
   always_comb begin
      op_conflict             = dec_load_i & dec_div_i;
      struct_hazard           = (dec_load_i & slot_busy[SLOT_LD]) |
                                (dec_div_i  & slot_busy[SLOT_DIV]);
      hazard                  = op_conflict | struct_hazard | (|slot_hit);
      issue_o                 = dec_valid_i & ~hazard & ~flush_i;
      stall_o                 = dec_valid_i &  hazard & ~flush_i;
      slot_capture[SLOT_LD]   = issue_o & dec_load_i;
      slot_capture[SLOT_DIV]  = issue_o & dec_div_i;
   end

   generate
      for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
         issue_slot u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .capture       (slot_capture[g]),
            .done          (slot_done[g]),
            .rs1_addr      (rs1_raddr_i),
            .rs2_addr      (rs2_raddr_i),
            .rd_addr       (rd_waddr_i),
            .rd_we         (rd_we_i),
            .busy          (slot_busy[g]),
            .data_hit      (slot_hit[g]),
            .spurious_done (slot_spurious[g])
         );
      end
   endgenerate

   // Saturating stall counter; a clear request takes priority over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (clr_cnt_i) begin
         stall_cnt <= '0;
      end else if (stall_o && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // Sticky error: completion on an empty slot, or a malformed decoded op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if ((|slot_spurious) || (dec_valid_i && op_conflict)) begin
         err <= 1'b1;
      end
   end

   assign ld_busy_o   = slot_busy[SLOT_LD];
   assign div_busy_o  = slot_busy[SLOT_DIV];
   assign stall_cnt_o = stall_cnt;
   assign err_o       = err;

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_ctrl
//  Description : Self-checking bench for issue_ctrl. Directed scenarios and a
//                randomized run, all compared against a behavioural model of
//                the two outstanding slots kept in this file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_ctrl;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int OW      = 5 + CNT_W;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       we;
      logic       ld;
      logic       dv;
      logic       fl;
      logic       ldd;
      logic       divd;
      logic       clr;
   } in_t;

   logic             clk;
   logic             rst_n;
   in_t              cur;
   logic             issue_o, stall_o, ld_busy_o, div_busy_o, err_o;
   logic [CNT_W-1:0] stall_cnt_o;

   int n_tot;
   int n_pass;

   // Reference model state: what each slot holds, counter, error flag
   bit         m_busy [2];
   logic [4:0] m_rd   [2];
   bit         m_rdv  [2];
   int         m_cnt;
   bit         m_err;

   issue_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dec_valid_i (cur.v),
      .rs1_raddr_i (cur.rs1),
      .rs2_raddr_i (cur.rs2),
      .rd_waddr_i  (cur.rd),
      .rd_we_i     (cur.we),
      .dec_load_i  (cur.ld),
      .dec_div_i   (cur.dv),
      .flush_i     (cur.fl),
      .ld_done_i   (cur.ldd),
      .div_done_i  (cur.divd),
      .clr_cnt_i   (cur.clr),
      .issue_o     (issue_o),
      .stall_o     (stall_o),
      .ld_busy_o   (ld_busy_o),
      .div_busy_o  (div_busy_o),
      .stall_cnt_o (stall_cnt_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t op(bit v, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, bit we, bit ld, bit dv);
      in_t t;
      t     = '0;
      t.v   = v;
      t.rs1 = rs1;
      t.rs2 = rs2;
      t.rd  = rd;
      t.we  = we;
      t.ld  = ld;
      t.dv  = dv;
      return t;
   endfunction

   function automatic bit m_hazard(in_t x);
      if (x.ld && x.dv) return 1'b1;
      if (x.ld && m_busy[0]) return 1'b1;
      if (x.dv && m_busy[1]) return 1'b1;
      for (int s = 0; s < 2; s++) begin
         if (m_busy[s] && m_rdv[s]) begin
            if (x.rs1 != 0 && x.rs1 == m_rd[s]) return 1'b1;
            if (x.rs2 != 0 && x.rs2 == m_rd[s]) return 1'b1;
            if (x.we && x.rd != 0 && x.rd == m_rd[s]) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [OW-1:0] m_expect(in_t x);
      bit h;
      bit iss;
      bit stl;
      h   = m_hazard(x);
      iss = x.v && !h && !x.fl;
      stl = x.v &&  h && !x.fl;
      return {iss, stl, m_busy[0], m_busy[1], m_err, CNT_W'(m_cnt)};
   endfunction

   task automatic m_reset();
      for (int s = 0; s < 2; s++) begin
         m_busy[s] = 1'b0;
         m_rd[s]   = '0;
         m_rdv[s]  = 1'b0;
      end
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   // Advance the model by one clock edge with inputs x applied.
   task automatic m_step(in_t x);
      bit h, iss, stl;
      bit dn [2];
      h     = m_hazard(x);
      iss   = x.v && !h && !x.fl;
      stl   = x.v &&  h && !x.fl;
      dn[0] = x.ldd;
      dn[1] = x.divd;
      for (int s = 0; s < 2; s++) begin
         if (dn[s] && !m_busy[s]) m_err = 1'b1;
         else if (dn[s])          m_busy[s] = 1'b0;
      end
      if (iss && x.ld) begin
         m_busy[0] = 1'b1; m_rd[0] = x.rd; m_rdv[0] = x.we && (x.rd != 0);
      end
      if (iss && x.dv) begin
         m_busy[1] = 1'b1; m_rd[1] = x.rd; m_rdv[1] = x.we && (x.rd != 0);
      end
      if (x.v && x.ld && x.dv) m_err = 1'b1;
      if (x.clr)                        m_cnt = 0;
      else if (stl && m_cnt < CNT_MAX)  m_cnt = m_cnt + 1;
   endtask

   // One clock: drive x, sample at the falling edge, then step the model.
   task automatic cyc(input in_t x, output logic [OW-1:0] obs, output logic [OW-1:0] exp);
      cur = x;
      @(negedge clk);
      obs = {issue_o, stall_o, ld_busy_o, div_busy_o, err_o, stall_cnt_o};
      exp = m_expect(x);
      @(posedge clk);
      m_step(x);
      #1;
   endtask

   task automatic apply_reset();
      cur   = '0;
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [OW-1:0] o, e;
      cur = op(1, 5'd5, 0, 0, 0, 0, 0);
      #2;
      o = {issue_o, stall_o, ld_busy_o, div_busy_o, err_o, stall_cnt_o};
      e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(0)};
      n_tot++;
      if (o !== e) $display("FAIL reset_state: got %h want %h", o, e); else n_pass++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_reset();
      // load in flight, then asynchronous reset mid-cycle discards it
      cyc(op(1, 0, 0, 5'd5, 1, 1, 0), o, e);
      n_tot++;
      if (o !== e) $display("FAIL reset_issue_ld: got %h want %h", o, e); else n_pass++;
      #3 rst_n = 1'b0;
      m_reset();
      #1;
      n_tot++;
      if (ld_busy_o !== 1'b0) $display("FAIL reset_async_clear: got %b want 0", ld_busy_o); else n_pass++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      begin
         in_t x;
         x = '0; x.ldd = 1'b1;
         cyc(x, o, e);
         n_tot++;
         if (o !== e) $display("FAIL reset_late_done: got %h want %h", o, e); else n_pass++;
      end
      cyc('0, o, e);
      n_tot++;
      if (o !== e || err_o !== 1'b1) $display("FAIL reset_late_err: got %h want %h", o, e); else n_pass++;
      apply_reset();
   endtask

   task automatic test_load_use();
      logic [OW-1:0] o, e;
      in_t x;
      cyc(op(1, 0, 0, 5'd5, 1, 1, 0), o, e);
      n_tot++;
      if (o !== e || o[OW-1] !== 1'b1) $display("FAIL load_use_issue: got %h want %h", o, e); else n_pass++;
      x = op(1, 5'd5, 5'd2, 5'd6, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         x.ldd = (i == 3);
         cyc(x, o, e);
         n_tot++;
         if (o !== e || (i <= 3 && o[OW-1:OW-2] !== 2'b01))
            $display("FAIL load_use_stall c%0d: got %h want %h", i, o, e);
         else n_pass++;
      end
      n_tot++;
      if (o[OW-1] !== 1'b1) $display("FAIL load_use_release: got issue %b want 1", o[OW-1]); else n_pass++;
      apply_reset();
   endtask

   task automatic test_structural();
      logic [OW-1:0] o, e;
      in_t x;
      cyc(op(1, 0, 0, 5'd7, 1, 0, 1), o, e);
      n_tot++;
      if (o !== e) $display("FAIL struct_div1: got %h want %h", o, e); else n_pass++;
      x = op(1, 5'd1, 0, 5'd9, 1, 0, 1);
      for (int i = 0; i < 2; i++) begin
         cyc(x, o, e);
         n_tot++;
         if (o !== e || o[OW-2] !== 1'b1) $display("FAIL struct_div2_stall c%0d: got %h want %h", i, o, e); else n_pass++;
      end
      cyc(op(1, 5'd2, 0, 5'd3, 1, 0, 0), o, e);
      n_tot++;
      if (o !== e || o[OW-1] !== 1'b1) $display("FAIL struct_unrelated_add: got %h want %h", o, e); else n_pass++;
      x.divd = 1'b1;
      cyc(x, o, e);
      n_tot++;
      if (o !== e || o[OW-2] !== 1'b1) $display("FAIL struct_done_cycle: got %h want %h", o, e); else n_pass++;
      x.divd = 1'b0;
      cyc(x, o, e);
      n_tot++;
      if (o !== e || o[OW-1] !== 1'b1) $display("FAIL struct_div2_issue: got %h want %h", o, e); else n_pass++;
      apply_reset();
   endtask

   task automatic test_flush();
      logic [OW-1:0] o, e;
      in_t x;
      cyc(op(1, 0, 0, 5'd5, 1, 1, 0), o, e);
      x = op(1, 5'd5, 0, 5'd8, 1, 0, 0);
      x.fl = 1'b1;
      cyc(x, o, e);
      n_tot++;
      if (o !== e || o[OW-1:OW-2] !== 2'b00) $display("FAIL flush_outputs: got %h want %h", o, e); else n_pass++;
      cyc('0, o, e);
      n_tot++;
      if (o !== e || ld_busy_o !== 1'b1 || stall_cnt_o !== CNT_W'(0))
         $display("FAIL flush_state: got %h want %h", o, e);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_x0();
      logic [OW-1:0] o, e;
      cyc(op(1, 0, 0, 5'd0, 1, 1, 0), o, e);
      cyc(op(1, 0, 0, 5'd0, 1, 0, 0), o, e);
      n_tot++;
      if (o !== e || o[OW-1] !== 1'b1) $display("FAIL x0_add_issue: got %h want %h", o, e); else n_pass++;
      cyc(op(1, 0, 0, 5'd4, 1, 1, 0), o, e);
      n_tot++;
      if (o !== e || o[OW-2] !== 1'b1) $display("FAIL x0_second_load: got %h want %h", o, e); else n_pass++;
      apply_reset();
   endtask

   task automatic test_counter_err();
      logic [OW-1:0] o, e;
      in_t x;
      cyc(op(1, 0, 0, 5'd5, 1, 1, 0), o, e);
      x = op(1, 5'd5, 0, 0, 0, 0, 0);
      repeat (10) cyc(x, o, e);
      cyc('0, o, e);
      n_tot++;
      if (o !== e || o[CNT_W-1:0] !== CNT_W'(10)) $display("FAIL cnt_ten: got %h want %h", o, e); else n_pass++;
      x.clr = 1'b1;
      cyc(x, o, e);
      x.clr = 1'b0;
      cyc('0, o, e);
      n_tot++;
      if (o !== e || o[CNT_W-1:0] !== CNT_W'(0)) $display("FAIL cnt_clear: got %h want %h", o, e); else n_pass++;
      repeat (CNT_MAX + 4) cyc(x, o, e);
      cyc('0, o, e);
      n_tot++;
      if (o !== e || o[CNT_W-1:0] !== CNT_W'(CNT_MAX)) $display("FAIL cnt_saturate: got %h want %h", o, e); else n_pass++;
      x     = '0;
      x.ldd = 1'b1;
      cyc(x, o, e);
      cyc(x, o, e);
      cyc('0, o, e);
      n_tot++;
      if (o !== e || err_o !== 1'b1) $display("FAIL err_idle_done: got %h want %h", o, e); else n_pass++;
      repeat (3) cyc('0, o, e);
      n_tot++;
      if (o !== e || err_o !== 1'b1) $display("FAIL err_sticky: got %h want %h", o, e); else n_pass++;
      apply_reset();
      #1;
      n_tot++;
      if (err_o !== 1'b0) $display("FAIL err_reset: got %b want 0", err_o); else n_pass++;
   endtask

   task automatic test_both();
      logic [OW-1:0] o, e;
      in_t x;
      cyc(op(1, 0, 0, 5'd5, 1, 1, 0), o, e);
      cyc(op(1, 0, 0, 5'd6, 1, 0, 1), o, e);
      x = '0; x.ldd = 1'b1; x.divd = 1'b1;
      cyc(x, o, e);
      n_tot++;
      if (o !== e || o[OW-3:OW-4] !== 2'b11) $display("FAIL both_busy: got %h want %h", o, e); else n_pass++;
      cyc('0, o, e);
      n_tot++;
      if (o !== e || o[OW-3:OW-4] !== 2'b00) $display("FAIL both_done: got %h want %h", o, e); else n_pass++;
      cyc(op(1, 0, 0, 5'd3, 1, 1, 1), o, e);
      n_tot++;
      if (o !== e || o[OW-1] !== 1'b0) $display("FAIL both_ops_issue: got %h want %h", o, e); else n_pass++;
      cyc('0, o, e);
      n_tot++;
      if (o !== e || err_o !== 1'b1) $display("FAIL both_ops_err: got %h want %h", o, e); else n_pass++;
      apply_reset();
   endtask

   task automatic test_random();
      logic [OW-1:0] o, e;
      in_t x;
      for (int i = 0; i < 400; i++) begin
         if (i % 80 == 79) apply_reset();
         x     = '0;
         x.v   = ($urandom_range(0, 3) != 0);
         x.rs1 = 5'($urandom_range(0, 7));
         x.rs2 = 5'($urandom_range(0, 7));
         x.rd  = 5'($urandom_range(0, 7));
         x.we  = ($urandom_range(0, 4) != 0);
         if (x.v) begin
            x.ld = ($urandom_range(0, 3) == 0);
            x.dv = !x.ld && ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 59) == 0) begin x.ld = 1'b1; x.dv = 1'b1; end
         end
         x.fl   = ($urandom_range(0, 9) == 0);
         x.ldd  = (m_busy[0] && $urandom_range(0, 2) == 0) || ($urandom_range(0, 149) == 0);
         x.divd = (m_busy[1] && $urandom_range(0, 3) == 0) || ($urandom_range(0, 149) == 0);
         x.clr  = ($urandom_range(0, 39) == 0);
         cyc(x, o, e);
         n_tot++;
         if (o !== e) $display("FAIL random c%0d: got %h want %h", i, o, e); else n_pass++;
      end
      apply_reset();
   endtask

   initial begin
      n_tot  = 0;
      n_pass = 0;
      rst_n  = 1'b0;
      cur    = '0;
      m_reset();
      test_reset();
      test_load_use();
      test_structural();
      test_flush();
      test_x0();
      test_counter_err();
      test_both();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
